// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared state type, LFSR constants and step function
// for lfsr_scheduler and lfsr_step_core.
package lfsr_pkg;

  localparam int LFSR_W = 16;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  // Galois right shift, x^16+x^14+x^13+x^11+1
  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] cur
  );
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/lfsr_step_core.sv
// lfsr_step_core: 16-bit Galois LFSR register with load and step.
// Load wins over step; the register holds otherwise.
module lfsr_step_core
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] load_val_i,
  input  logic              step_i,
  output logic [LFSR_W-1:0] value_o
);

  logic [LFSR_W-1:0] value_q;
  logic [LFSR_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (step_i) begin
      value_d = lfsr_next(value_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/lfsr_scheduler.sv
// lfsr_scheduler: round-robin dispenser of words from one shared LFSR.
// Define LFSR_SCHEDULER_LOCKUP_GUARD_EN to reseed on an all-zero state.
module lfsr_scheduler
  import lfsr_pkg::*;
#(
  parameter int                NUM_REQ      = 4,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_SEED_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seed_valid,
  input  logic [LFSR_W-1:0]  seed,
  output logic               seed_ready,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [LFSR_W-1:0]  rnd_data,
  output logic               seeded
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e state_q;
  state_e state_d;

  logic [LFSR_W-1:0]  seed_q;
  logic [LFSR_W-1:0]  seed_d;
  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] req_d;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      ptr_d;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] gnt_d;
  logic               rnd_valid_q;
  logic               rnd_valid_d;
  logic [LFSR_W-1:0]  rnd_data_q;
  logic [LFSR_W-1:0]  rnd_data_d;
  logic               seeded_q;
  logic               seeded_d;

  logic               hs;
  logic               lockup;
  logic               grant_ok;
  logic               found;
  logic [PW-1:0]      sel;
  logic               core_load;
  logic [LFSR_W-1:0]  core_load_val;
  logic [LFSR_W-1:0]  lfsr_val;

  assign seed_ready = (state_q != ST_LOAD);
  assign hs         = seed_valid && seed_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (hs) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_ACTIVE;
      ST_ACTIVE: if (hs) state_d = ST_LOAD;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lockup = 1'b0;
`ifdef LFSR_SCHEDULER_LOCKUP_GUARD_EN
    lockup = (state_q == ST_ACTIVE) && (lfsr_val == '0);
`endif
  end

  // Rotating priority: scan from ptr_q upward, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req_q[k]) begin
        found = 1'b1;
        sel   = PW'(k);
      end
    end
  end

  assign grant_ok = (state_q == ST_ACTIVE) && !hs
                 && !lockup && found;

  always_comb begin
    gnt_d       = '0;
    rnd_valid_d = 1'b0;
    rnd_data_d  = '0;
    ptr_d       = ptr_q;
    if (grant_ok) begin
      gnt_d       = NUM_REQ'(1) << sel;
      rnd_valid_d = 1'b1;
      rnd_data_d  = lfsr_val;
      ptr_d       = (sel == PW'(NUM_REQ - 1)) ? '0
                  : sel + 1'b1;
    end
  end

  // Requests only count when sampled in a settled ACTIVE cycle.
  assign req_d    = (state_q == ST_ACTIVE && !hs) ? req : '0;
  assign seed_d   = hs ? seed : seed_q;
  assign seeded_d = seeded_q | (state_q == ST_LOAD);

  always_comb begin
    core_load     = (state_q == ST_LOAD) || lockup;
    core_load_val = (seed_q == '0) ? SEED_DEFAULT : seed_q;
    if (lockup) begin
      core_load_val = SEED_DEFAULT;
    end
  end

  lfsr_step_core u_core (
    .clk        (clk),
    .reset      (reset),
    .load_i     (core_load),
    .load_val_i (core_load_val),
    .step_i     (grant_ok),
    .value_o    (lfsr_val)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      seed_q      <= '0;
      req_q       <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
      seeded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      req_q       <= req_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
      seeded_q    <= seeded_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_valid = rnd_valid_q;
  assign rnd_data  = rnd_data_q;
  assign seeded    = seeded_q;

endmodule

// File: tb/tb_lfsr_scheduler.sv
// tb_lfsr_scheduler: directed checks of lfsr_scheduler with
// hand-computed grant patterns and LFSR words.
module tb_lfsr_scheduler;

  logic        clk;
  logic        reset;
  logic        seed_valid;
  logic [15:0] seed;
  logic        seed_ready;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        rnd_valid;
  logic [15:0] rnd_data;
  logic        seeded;

  int n_run;
  int n_fail;

  lfsr_scheduler #(
    .NUM_REQ      (4),
    .SEED_DEFAULT (16'hACE1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seed_valid (seed_valid),
    .seed       (seed),
    .seed_ready (seed_ready),
    .req        (req),
    .gnt        (gnt),
    .rnd_valid  (rnd_valid),
    .rnd_data   (rnd_data),
    .seeded     (seeded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake then pass the LOAD cycle; ends in ACTIVE.
  task automatic do_seed(input logic [15:0] v);
    seed_valid = 1'b1;
    seed       = v;
    tick();
    seed_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();
  endtask

  logic [3:0]  exp_g [8];
  logic [15:0] exp_d [8];

  initial begin
    n_run      = 0;
    n_fail     = 0;
    reset      = 1'b0;
    seed_valid = 1'b0;
    seed       = '0;
    req        = '0;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
              4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_d = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C,
              16'h1C4E, 16'h0E27, 16'hB313, 16'hED89};

    #12;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(rnd_valid), 32'h0);
    chk("rst_data", 32'(rnd_data), 32'h0);
    chk("rst_seeded", 32'(seeded), 32'h0);
    reset = 1'b1;
    tick();
    chk("idle_ready", 32'(seed_ready), 32'h1);

    // idle requests are ignored
    req = 4'b0001;
    tick();
    tick();
    chk("idle_nognt", 32'(gnt), 32'h0);

    // seed ACE1, single requester
    seed_valid = 1'b1;
    seed       = 16'hACE1;
    tick();
    seed_valid = 1'b0;
    chk("load_ready", 32'(seed_ready), 32'h0);
    chk("load_nognt", 32'(gnt), 32'h0);
    tick();
    chk("act_seeded", 32'(seeded), 32'h1);
    chk("act_ready", 32'(seed_ready), 32'h1);
    chk("act_nognt", 32'(gnt), 32'h0);
    tick();
    chk("s0_gnt", 32'(gnt), 32'h0);
    tick();
    chk("g1_gnt", 32'(gnt), 32'b0001);
    chk("g1_valid", 32'(rnd_valid), 32'h1);
    chk("g1_data", 32'(rnd_data), 32'hACE1);
    tick();
    chk("g2_gnt", 32'(gnt), 32'b0001);
    chk("g2_data", 32'(rnd_data), 32'hE270);
    req = '0;
    tick();
    chk("g3_data", 32'(rnd_data), 32'h7138);
    tick();
    chk("drain_gnt", 32'(gnt), 32'h0);
    chk("drain_valid", 32'(rnd_valid), 32'h0);
    tick();
    chk("hold_gnt", 32'(gnt), 32'h0);

    // full round robin from a fresh reset
    do_reset();
    do_seed(16'hACE1);
    req = 4'b1111;
    tick();
    chk("rr_lat", 32'(gnt), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(exp_g[i]));
      chk($sformatf("rr_val%0d", i), 32'(rnd_valid), 32'h1);
      chk($sformatf("rr_dat%0d", i), 32'(rnd_data),
          32'(exp_d[i]));
    end
    req = '0;
    tick();
    chk("rr_wrap", 32'(gnt), 32'b0001);
    tick();
    chk("rr_stop", 32'(gnt), 32'h0);

    // reseed collides with a request; pointer now at 1
    seed_valid = 1'b1;
    seed       = 16'h1234;
    req        = 4'b0010;
    tick();
    seed_valid = 1'b0;
    chk("hs_nognt", 32'(gnt), 32'h0);
    chk("hs_ready", 32'(seed_ready), 32'h0);
    tick();
    chk("hs_load_nognt", 32'(gnt), 32'h0);
    tick();
    chk("hs_act_nognt", 32'(gnt), 32'h0);
    tick();
    chk("hs_gnt", 32'(gnt), 32'b0010);
    chk("hs_data", 32'(rnd_data), 32'h1234);
    tick();
    chk("hs_gnt2", 32'(gnt), 32'b0010);
    chk("hs_data2", 32'(rnd_data), 32'h091A);
    req = '0;
    tick();
    tick();

    // zero seed falls back to the default
    do_reset();
    do_seed(16'h0000);
    req = 4'b0100;
    tick();
    tick();
    chk("z_gnt", 32'(gnt), 32'b0100);
    chk("z_data", 32'(rnd_data), 32'hACE1);

    // asynchronous reset mid-burst
    req = 4'b1111;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 32'h0);
    chk("ar_valid", 32'(rnd_valid), 32'h0);
    chk("ar_data", 32'(rnd_data), 32'h0);
    chk("ar_seeded", 32'(seeded), 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ar_ign%0d", i), 32'(gnt), 32'h0);
    end
    chk("ar_ready", 32'(seed_ready), 32'h1);
    do_seed(16'hACE1);
    tick();
    tick();
    chk("ar_gnt1", 32'(gnt), 32'b0001);
    chk("ar_dat1", 32'(rnd_data), 32'hACE1);
    req = '0;
    tick();
    tick();

`ifdef LFSR_SCHEDULER_LOCKUP_GUARD_EN
    req = 4'b0001;
    tick();
    force dut.u_core.value_q = 16'h0000;
    @(negedge clk);
    release dut.u_core.value_q;
    tick();
    chk("lk_nognt", 32'(gnt), 32'h0);
    chk("lk_value", 32'(dut.u_core.value_q), 32'hACE1);
    tick();
    chk("lk_data", 32'(rnd_data), 32'hACE1);
    req = '0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
